// File: rtl/uart_receiver_if.sv
// Receive-side bus between uart_receiver (master) and the consuming core (slave).
// Carries the holding-register payload, its valid/ready handshake, and per-frame status.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output frame_err,
        output parity_err,
        output overrun
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  frame_err,
        input  parity_err,
        input  overrun
    );
endinterface

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver with a valid/ready holding register and per-frame error flags.
// Optional parity bit checking is enabled by defining UART_PARITY_EN.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enb_rx,
    input  logic            rx,
    uart_receiver_if.master rx_bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;
`ifdef UART_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic       PAR_SENSE = (PARITY_ODD != 0);
`endif

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 stop_tick;
    logic                 perr_next;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 perr_q;
    logic                 ovr_q;

    // rx is asynchronous to clock; the synchroniser idles high like the line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign stop_tick = enb_rx && (state == ST_STOP) && (tick_cnt == TICK_LAST);

`ifdef UART_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            parity_bit <= 1'b0;
        else if (enb_rx && state == ST_PARITY && tick_cnt == TICK_LAST)
            parity_bit <= rx_s;
    end

    assign perr_next = ((^shift_reg) ^ parity_bit) != PAR_SENSE;
`else
    assign perr_next = 1'b0;
`endif

    // Data bits arrive LSB first, so shifting in at the MSB leaves bit 0 at the bottom.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (enb_rx) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (tick_cnt == TICK_HALF) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt  <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        state    <= ST_STOP;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        state    <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s)
                        state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    // A frame completing while the held one is still unread is dropped, not merged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (stop_tick) begin
                if (!valid_q || rx_bus.rx_ready) begin
                    data_q  <= shift_reg;
                    ferr_q  <= ~rx_s;
                    perr_q  <= perr_next;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data    = data_q;
    assign rx_bus.rx_valid   = valid_q;
    assign rx_bus.frame_err  = ferr_q;
    assign rx_bus.parity_err = perr_q;
    assign rx_bus.overrun    = ovr_q;

endmodule
